// File: rtl/alu_pipe_acc.sv
// Two-stage pipelined signed ALU with an internal accumulator, optional
// saturation, signed-overflow reporting and valid/ready flow control.
module alu_pipe_acc #(
    parameter int unsigned WIDTH    = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ovf
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             r_s1_valid;
    op_e              r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;
    logic [WIDTH-1:0] r_acc;

    logic             w_en1;
    logic             w_en2;
    logic             w_accept;
    logic             w_commit;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_c;
    logic [WIDTH:0]   w_sum;
    logic             w_sum_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_res_ovf;
    logic             w_acc_upd;

    assign w_en2    = !r_out_valid || out_ready;
    assign w_en1    = !r_s1_valid || w_en2;
    assign w_accept = in_valid && w_en1;
    assign w_commit = r_s1_valid && w_en2;

    assign in_ready  = w_en1;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign ovf       = r_ovf;

    // One shared WIDTH+1 adder; SUB feeds ~b with inverted borrow, ACC swaps in acc.
    always_comb begin
        w_x = r_s1_a;
        w_y = r_s1_b;
        w_c = r_s1_cin;
        case (r_s1_op)
            OP_SUB: begin
                w_y = ~r_s1_b;
                w_c = ~r_s1_cin;
            end
            OP_ACC: begin
                w_x = r_acc;
                w_y = r_s1_a;
            end
            OP_LOAD: w_c = 1'b0;
            default: ;
        endcase
    end

    assign w_sum     = {w_x[WIDTH-1], w_x} + {w_y[WIDTH-1], w_y} + {{WIDTH{1'b0}}, w_c};
    assign w_sum_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    assign w_acc_upd = (r_s1_op == OP_ACC) || (r_s1_op == OP_LOAD);

    always_comb begin
        w_res     = w_sum[WIDTH-1:0];
        w_res_ovf = w_sum_ovf;
        if (r_s1_op == OP_LOAD) begin
            w_res     = r_s1_a;
            w_res_ovf = 1'b0;
        end else if (w_sum_ovf && SATURATE) begin
            w_res = w_sum[WIDTH] ? MIN_NEG : MAX_POS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_cin   <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= op_e'(op);
            r_s1_a     <= a;
            r_s1_b     <= b;
            r_s1_cin   <= cin;
        end else if (w_en1) begin
            r_s1_valid <= 1'b0;
        end
    end

    // acc moves only on commit, so a stalled op in S1 can never apply twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
            r_acc       <= '0;
        end else if (w_commit) begin
            r_out_valid <= 1'b1;
            r_out       <= w_res;
            r_ovf       <= w_res_ovf;
            if (w_acc_upd) begin
                r_acc <= w_res;
            end
        end else if (w_en2) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe_acc.sv
// Directed bench: a saturating and a wrapping instance share one stimulus stream.
module tb_alu_pipe_acc;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] ACC  = 2'b10;
    localparam logic [1:0] LOAD = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_ready = 1'b1;

    logic        s_in_ready, s_out_valid, s_ovf;
    logic [15:0] s_out;
    logic        w_in_ready, w_out_valid, w_ovf;
    logic [15:0] w_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_pipe_acc #(.WIDTH(16), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .op(op), .a(a), .b(b), .cin(cin), .out_valid(s_out_valid),
        .out_ready(out_ready), .out(s_out), .ovf(s_ovf)
    );

    alu_pipe_acc #(.WIDTH(16), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .op(op), .a(a), .b(b), .cin(cin), .out_valid(w_out_valid),
        .out_ready(out_ready), .out(w_out), .ovf(w_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [15:0] aa,
                         input logic [15:0] bb, input logic c);
        in_valid = v;
        op       = o;
        a        = aa;
        b        = bb;
        cin      = c;
    endtask

    task automatic idle();
        drive(1'b0, ADD, 16'h0, 16'h0, 1'b0);
    endtask

    // Checks a valid result on both instances (sat and wrap expectations may differ).
    task automatic chk_res(input string tag, input logic [15:0] es, input logic eso,
                           input logic [15:0] ew, input logic ewo);
        chk({tag, "_sat_vld"}, {31'b0, s_out_valid}, 32'd1);
        chk({tag, "_sat_out"}, {16'b0, s_out}, {16'b0, es});
        chk({tag, "_sat_ovf"}, {31'b0, s_ovf}, {31'b0, eso});
        chk({tag, "_wrap_vld"}, {31'b0, w_out_valid}, 32'd1);
        chk({tag, "_wrap_out"}, {16'b0, w_out}, {16'b0, ew});
        chk({tag, "_wrap_ovf"}, {31'b0, w_ovf}, {31'b0, ewo});
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_sat_vld"}, {31'b0, s_out_valid}, 32'd0);
        chk({tag, "_wrap_vld"}, {31'b0, w_out_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_empty("rst");
        chk("rst_out", {16'b0, s_out}, 32'h0);
        chk("rst_ovf", {31'b0, s_ovf}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {30'b0, s_in_ready, w_in_ready}, 32'h3);

        // ADD 0x7FFF + 1: accept, then result after the next edge
        drive(1'b1, ADD, 16'h7FFF, 16'h0001, 1'b0);
        tick();
        idle();
        chk_empty("add_ovf_lat");
        tick();
        chk_res("add_ovf", 16'h7FFF, 1'b1, 16'h8000, 1'b1);

        // SUB cases
        drive(1'b1, SUB, 16'd5, 16'd3, 1'b0);
        tick();
        drive(1'b1, SUB, 16'd5, 16'd3, 1'b1);
        tick();
        chk_res("sub_5_3", 16'd2, 1'b0, 16'd2, 1'b0);
        drive(1'b1, SUB, 16'h8000, 16'h0001, 1'b0);
        tick();
        chk_res("sub_5_3_b", 16'd1, 1'b0, 16'd1, 1'b0);
        idle();
        tick();
        chk_res("sub_min", 16'h8000, 1'b1, 16'h7FFF, 1'b1);
        tick();
        chk_empty("sub_drain");

        // LOAD 10 then three back-to-back ACC 5
        drive(1'b1, LOAD, 16'd10, 16'h0, 1'b0);
        tick();
        drive(1'b1, ACC, 16'd5, 16'h0, 1'b0);
        tick();
        chk_res("acc_seq0", 16'd10, 1'b0, 16'd10, 1'b0);
        tick();
        chk_res("acc_seq1", 16'd15, 1'b0, 16'd15, 1'b0);
        tick();
        chk_res("acc_seq2", 16'd20, 1'b0, 16'd20, 1'b0);
        drive(1'b1, ACC, 16'd0, 16'h0, 1'b0);
        tick();
        chk_res("acc_seq3", 16'd25, 1'b0, 16'd25, 1'b0);
        idle();
        tick();
        chk_res("acc_read25", 16'd25, 1'b0, 16'd25, 1'b0);
        tick();

        // Five ADDs with out_ready low for four edges
        out_ready = 1'b0;
        drive(1'b1, ADD, 16'd0, 16'd100, 1'b0);
        tick();
        chk("stall_rdy1", {31'b0, s_in_ready}, 32'd1);
        drive(1'b1, ADD, 16'd1, 16'd100, 1'b0);
        tick();
        chk("stall_rdy2", {31'b0, s_in_ready}, 32'd0);
        chk_res("stall_first", 16'd100, 1'b0, 16'd100, 1'b0);
        drive(1'b1, ADD, 16'd2, 16'd100, 1'b0);
        tick();
        chk("stall_rdy3", {31'b0, s_in_ready}, 32'd0);
        chk_res("stall_hold1", 16'd100, 1'b0, 16'd100, 1'b0);
        tick();
        chk_res("stall_hold2", 16'd100, 1'b0, 16'd100, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("stall_rdy_release", {31'b0, s_in_ready}, 32'd1);
        tick();
        chk_res("stream1", 16'd101, 1'b0, 16'd101, 1'b0);
        drive(1'b1, ADD, 16'd3, 16'd100, 1'b0);
        tick();
        chk_res("stream2", 16'd102, 1'b0, 16'd102, 1'b0);
        drive(1'b1, ADD, 16'd4, 16'd100, 1'b0);
        tick();
        chk_res("stream3", 16'd103, 1'b0, 16'd103, 1'b0);
        idle();
        tick();
        chk_res("stream4", 16'd104, 1'b0, 16'd104, 1'b0);
        tick();
        chk_empty("stream_drain");

        // ACC 1 twice with out_ready 1,0,0,1
        drive(1'b1, LOAD, 16'd0, 16'h0, 1'b0);
        tick();
        drive(1'b1, ACC, 16'd1, 16'h0, 1'b0);
        tick();
        chk_res("ilv_load", 16'd0, 1'b0, 16'd0, 1'b0);
        tick();
        chk_res("ilv_acc1", 16'd1, 1'b0, 16'd1, 1'b0);
        idle();
        out_ready = 1'b0;
        tick();
        chk_res("ilv_hold1", 16'd1, 1'b0, 16'd1, 1'b0);
        tick();
        chk_res("ilv_hold2", 16'd1, 1'b0, 16'd1, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_res("ilv_acc2", 16'd2, 1'b0, 16'd2, 1'b0);
        drive(1'b1, ACC, 16'd3, 16'h0, 1'b1);
        tick();
        idle();
        tick();
        chk_res("ilv_acc_cin", 16'd6, 1'b0, 16'd6, 1'b0);

        // ACC overflow leaves different acc values per mode
        drive(1'b1, LOAD, 16'h7FF0, 16'h0, 1'b0);
        tick();
        drive(1'b1, ACC, 16'h0020, 16'h0, 1'b0);
        tick();
        drive(1'b1, ACC, 16'h0000, 16'h0, 1'b0);
        tick();
        chk_res("acc_ovf", 16'h7FFF, 1'b1, 16'h8010, 1'b1);
        idle();
        tick();
        chk_res("acc_after_ovf", 16'h7FFF, 1'b0, 16'h8010, 1'b0);
        tick();

        // Reset with two operations in flight and acc = 25
        drive(1'b1, LOAD, 16'd25, 16'h0, 1'b0);
        tick();
        out_ready = 1'b0;
        drive(1'b1, ADD, 16'd1, 16'd1, 1'b0);
        tick();
        drive(1'b1, ADD, 16'd2, 16'd2, 1'b0);
        tick();
        chk("inflight_full", {31'b0, s_in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk_empty("midrst");
        chk("midrst_out", {16'b0, s_out}, 32'h0);
        chk("midrst_ovf", {31'b0, s_ovf}, 32'h0);
        idle();
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk_empty("post_rst");
        drive(1'b1, ACC, 16'd0, 16'h0, 1'b0);
        tick();
        drive(1'b1, LOAD, 16'd7, 16'h0, 1'b0);
        tick();
        chk_res("acc_cleared", 16'd0, 1'b0, 16'd0, 1'b0);
        idle();
        tick();
        chk_res("load7", 16'd7, 1'b0, 16'd7, 1'b0);
        tick();
        chk_empty("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
